// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one of N requesters ownership of a shared resource for a multi-beat burst.
// Latency: request to registered grant in one cycle; one zero-grant turnaround cycle between owners.
// Backpressure: rdy low stalls the owner indefinitely; bursts are cut after MAXBEATS accepted beats.
module rr_burst_arbiter #(
    parameter int N        = 4,
    parameter int MAXBEATS = 8,
    parameter int CNT_W    = $clog2(MAXBEATS + 1),
    parameter int IDW      = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     last,
    input  logic             rdy,
    output logic [N-1:0]     grant,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             preempt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    // Search start for the next arbitration; only moves when a burst ends.
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;

    logic [N-1:0]     grant_d;
    logic [IDW-1:0]   gnt_id_d;
    logic             busy_d;
    logic [CNT_W-1:0] cnt_d;
    logic             preempt_d;

    logic             arb_found;
    logic [IDW-1:0]   arb_win;

    logic             own_req;
    logic             own_last;
    logic             accept;
    logic             at_max;
    logic             burst_end;
    logic [IDW-1:0]   ptr_after_owner;

    // Rotating priority search: first set req bit at or after ptr_q, wrapping modulo N.
    always_comb begin : arb_search
        int idx;
        arb_found = 1'b0;
        arb_win   = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!arb_found && req[IDW'(idx)]) begin
                arb_found = 1'b1;
                arb_win   = IDW'(idx);
            end
        end
    end

    // Only the current owner's req/last matter; gnt_id is zero outside OWN and never read there.
    assign own_req  = req[gnt_id];
    assign own_last = last[gnt_id];
    assign accept   = (state_q == OWN) && rdy && own_req;
    assign at_max   = (beat_cnt == CNT_W'(MAXBEATS - 1));

    // Abort (owner dropped req) takes priority; otherwise an accepted last or MAXBEATS-th beat closes.
    assign burst_end = (state_q == OWN) && (!own_req || (accept && (own_last || at_max)));

    // Owner moves to lowest priority for the next round.
    assign ptr_after_owner = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;

    // Next-state and next-output logic for the IDLE / OWN / GAP sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant;
        gnt_id_d  = gnt_id;
        busy_d    = busy;
        cnt_d     = beat_cnt;
        preempt_d = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                grant_d  = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                cnt_d    = '0;
                if (arb_found) begin
                    state_d          = OWN;
                    grant_d[arb_win] = 1'b1;
                    gnt_id_d         = arb_win;
                    busy_d           = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            OWN: begin
                if (burst_end) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    gnt_id_d  = '0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    ptr_d     = ptr_after_owner;
                    // A last beat landing on the cap is still a normal end.
                    preempt_d = accept && at_max && !own_last;
                end else if (accept) begin
                    cnt_d = beat_cnt + 1'b1;
                end
            end

            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant    <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant    <= grant_d;
            gnt_id   <= gnt_id_d;
            busy     <= busy_d;
            beat_cnt <= cnt_d;
            preempt  <= preempt_d;
        end
    end

    // Structural invariants of the grant and counter.
    grant_onehot_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    cnt_bound_a    : assert property (@(posedge clk) disable iff (!rst_n)
                                      beat_cnt <= CNT_W'(MAXBEATS - 1));

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// The model tracks the owner as an integer and applies the burst rules each clock edge.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_rr_burst_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 8;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int IDW  = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic          rdy;
    logic [N-1:0]  grant;
    logic [IDW-1:0] gnt_id;
    logic          busy;
    logic [CW-1:0] beat_cnt;
    logic          preempt;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner index (-1 = none), rotating start, beats taken, preempt flag.
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_pre;

    logic [N-1:0]   e_grant;
    logic [IDW-1:0] e_id;
    logic           e_busy;
    logic [CW-1:0]  e_cnt;

    rr_burst_arbiter #(.N(N), .MAXBEATS(MAXB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .last     (last),
        .rdy      (rdy),
        .grant    (grant),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .beat_cnt (beat_cnt),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_pre   = 1'b0;
    endtask

    function automatic int pick(int ptr, logic [N-1:0] r);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (ptr + k) % N;
            if (r[i[IDW-1:0]]) return i;
        end
        return -1;
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        int  w;
        bit  ended;
        bit  cut;
        ended = 1'b0;
        cut   = 1'b0;
        m_pre = 1'b0;
        if (m_owner >= 0) begin
            if (!req[m_owner[IDW-1:0]]) begin
                ended = 1'b1;
            end else if (rdy) begin
                if (last[m_owner[IDW-1:0]]) begin
                    ended = 1'b1;
                end else if (m_cnt + 1 == MAXB) begin
                    ended = 1'b1;
                    cut   = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (ended) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
                m_pre   = cut;
            end
        end else begin
            w = pick(m_ptr, req);
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        rdy   = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        rdy   = 1'b0;
        model_reset();
        #3;
        checks++;
        if ({grant, gnt_id, busy, beat_cnt, preempt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0", {grant, gnt_id, busy, beat_cnt, preempt});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: grant %b busy %b expected 0 0", grant, busy);
        end
    endtask

    task automatic test_single_burst();
        req  = 4'b0001;
        rdy  = 1'b1;
        last = '0;
        tick();
        checks++;
        if (grant !== 4'b0001 || beat_cnt !== CW'(0)) begin
            errors++;
            $display("FAIL single_grant: grant %b cnt %0d expected 0001 0", grant, beat_cnt);
        end
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (grant !== 4'b0001 || beat_cnt !== CW'(k)) begin
                errors++;
                $display("FAIL single_beat: grant %b cnt %0d expected 0001 %0d", grant, beat_cnt, k);
            end
        end
        last = 4'b0001;
        tick();
        checks++;
        if (grant !== '0 || busy !== 1'b0 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL single_end: grant %b busy %b preempt %b expected 0 0 0", grant, busy, preempt);
        end
        req  = '0;
        last = '0;
        tick();
        checks++;
        if (grant !== '0 || busy !== 1'b0 || beat_cnt !== CW'(0)) begin
            errors++;
            $display("FAIL single_idle: grant %b busy %b cnt %0d expected 0 0 0", grant, busy, beat_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        do_reset();
        req  = 4'b1111;
        last = 4'b1111;
        rdy  = 1'b1;
        for (int s = 0; s < 9; s++) begin
            tick();
            exp_g = '0;
            if (s % 2 == 0) exp_g[(s / 2) % N] = 1'b1;
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL rr_order step %0d: grant %b expected %b", s, grant, exp_g);
            end
        end
        req  = '0;
        last = '0;
        tick();
        tick();
    endtask

    task automatic test_preempt();
        req  = 4'b0100;
        last = '0;
        rdy  = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL pre_grant: grant %b expected 0100", grant);
        end
        req = 4'b1111;
        for (int k = 1; k < MAXB; k++) begin
            tick();
            checks++;
            if (grant !== 4'b0100 || beat_cnt !== CW'(k) || preempt !== 1'b0) begin
                errors++;
                $display("FAIL pre_beat: grant %b cnt %0d preempt %b expected 0100 %0d 0",
                         grant, beat_cnt, preempt, k);
            end
        end
        tick();
        checks++;
        if (grant !== '0 || preempt !== 1'b1) begin
            errors++;
            $display("FAIL pre_cut: grant %b preempt %b expected 0 1", grant, preempt);
        end
        tick();
        checks++;
        if (grant !== 4'b1000 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL pre_next: grant %b preempt %b expected 1000 0", grant, preempt);
        end
    endtask

    task automatic test_wrap_coincide();
        req  = 4'b1011;
        last = '0;
        rdy  = 1'b1;
        for (int k = 1; k < MAXB; k++) tick();
        checks++;
        if (beat_cnt !== CW'(MAXB - 1) || grant !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_fill: cnt %0d grant %b expected %0d 1000", beat_cnt, grant, MAXB - 1);
        end
        last = 4'b1000;
        tick();
        checks++;
        if (grant !== '0 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: grant %b preempt %b expected 0 0", grant, preempt);
        end
        req  = 4'b0011;
        last = '0;
        tick();
        checks++;
        if (grant !== 4'b0001 || gnt_id !== IDW'(0)) begin
            errors++;
            $display("FAIL wrap_next: grant %b id %0d expected 0001 0", grant, gnt_id);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_stall_abort();
        req  = 4'b0010;
        last = '0;
        rdy  = 1'b0;
        tick();
        rdy = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0010 || beat_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL stall_first: grant %b cnt %0d expected 0010 1", grant, beat_cnt);
        end
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (grant !== 4'b0010 || beat_cnt !== CW'(1)) begin
                errors++;
                $display("FAIL stall_hold %0d: grant %b cnt %0d expected 0010 1", k, grant, beat_cnt);
            end
        end
        req = '0;
        rdy = 1'b1;
        tick();
        checks++;
        if (grant !== '0 || busy !== 1'b0 || beat_cnt !== CW'(0) || preempt !== 1'b0) begin
            errors++;
            $display("FAIL abort: grant %b busy %b cnt %0d preempt %b expected 0 0 0 0",
                     grant, busy, beat_cnt, preempt);
        end
        tick();
    endtask

    task automatic test_async_reset();
        req  = 4'b0001;
        last = '0;
        rdy  = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (grant !== 4'b0001 || beat_cnt !== CW'(4)) begin
            errors++;
            $display("FAIL areset_pre: grant %b cnt %0d expected 0001 4", grant, beat_cnt);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({grant, gnt_id, busy, beat_cnt} !== '0) begin
            errors++;
            $display("FAIL areset_now: got %0h expected 0", {grant, gnt_id, busy, beat_cnt});
        end
        #1;
        rst_n = 1'b1;
        req   = 4'b1111;
        last  = 4'b1111;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL areset_ptr: grant %b expected 0001", grant);
        end
        req  = '0;
        last = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int n_pre;
        n_pre = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
                last[i] = ($urandom_range(5) == 0);
            end
            rdy = ($urandom_range(2) != 0);
            tick();
            e_grant = '0;
            if (m_owner >= 0) e_grant[m_owner[IDW-1:0]] = 1'b1;
            e_id   = (m_owner >= 0) ? m_owner[IDW-1:0] : '0;
            e_busy = (m_owner >= 0);
            e_cnt  = CW'(m_cnt);
            if (m_pre) n_pre++;
            checks++;
            if ({grant, gnt_id, busy, beat_cnt, preempt} !== {e_grant, e_id, e_busy, e_cnt, m_pre}) begin
                errors++;
                $display("FAIL random cycle %0d: grant %b id %0d busy %b cnt %0d pre %b expected %b %0d %b %0d %b",
                         c, grant, gnt_id, busy, beat_cnt, preempt, e_grant, e_id, e_busy, e_cnt, m_pre);
            end
        end
        checks++;
        if (n_pre == 0) begin
            errors++;
            $display("FAIL random_preempt_seen: got 0 preempts expected at least 1");
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_preempt();
        test_wrap_coincide();
        test_stall_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
